ram_mem_ctrl: RTL

Clocked, parametrised byte-addressed big-endian data memory for the ARM datapath, the successor to the untimed 256x8 RAM. It serves the control unit's MOV/MOC memory handshake with a real state machine, configurable wait states, and a size generic in address width. It adds two-beat double-word transfers, alignment checking with a fault flag, and address wrap-around. It sits between the MAR/MDR datapath and the control unit.

---
 rtl/ram_mem_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/ram_mem_ctrl.sv
// ram_mem_ctrl: clocked big-endian byte RAM with MOV/MOC handshake, wait states, doubleword beats and alignment fault
// Ports: Clk clock; ResetN async active-low reset; MOV/ReadWrite/Address/DataIn/DataType/SIGN request fields
// latched at capture; DataOut registered read data; MOC one-cycle completion pulse per beat; Fault misalignment flag
module ram_mem_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic                  MOV,
  input  logic                  ReadWrite,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           DataIn,
  input  logic [1:0]            DataType,
  input  logic                  SIGN,
  output logic [31:0]           DataOut,
  output logic                  MOC,
  output logic                  Fault
);
  typedef enum logic [2:0] {IDLE, WAIT, XFER, BEAT2, HOLD} state_t;
  localparam logic [3:0] CNT0 = 4'(WAIT_STATES - 1);
  state_t state, nxt;
  logic [7:0] mem [2**ADDR_WIDTH];
  logic [3:0] cnt;
  logic rw, sgn, beat, mis;
  logic [1:0] dtype;
  logic [ADDR_WIDTH-1:0] addr, a1, a2, a3;
  logic [31:0] wdata, rdata;
  logic [7:0] b0, b1, b2, b3;
  assign a1 = addr + ADDR_WIDTH'(1);
  assign a2 = addr + ADDR_WIDTH'(2);
  assign a3 = addr + ADDR_WIDTH'(3);
  assign b0 = mem[addr];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];
  assign mis = (dtype == 2'b01 && addr[0]) || (dtype[1] && addr[1:0] != 2'b00);
  assign rdata = dtype == 2'b00 ? {{24{sgn & b0[7]}}, b0} :
                 dtype == 2'b01 ? {{16{sgn & b0[7]}}, b0, b1} : {b0, b1, b2, b3};
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = MOV ? (WAIT_STATES > 0 ? WAIT : XFER) : IDLE;
      WAIT:    nxt = cnt == 4'd0 ? XFER : WAIT;
      XFER:    nxt = (dtype == 2'b11 && !beat && !mis) ? BEAT2 : HOLD;
      BEAT2:   nxt = WAIT_STATES > 0 ? WAIT : XFER;
      HOLD:    nxt = MOV ? HOLD : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge ResetN)
    if (!ResetN) begin
      state   <= IDLE;
      cnt     <= '0;
      DataOut <= '0;
      MOC     <= 1'b0;
      Fault   <= 1'b0;
      rw      <= 1'b0;
      sgn     <= 1'b0;
      beat    <= 1'b0;
      dtype   <= '0;
      addr    <= '0;
      wdata   <= '0;
    end else begin
      state <= nxt;
      MOC   <= 1'b0;
      Fault <= 1'b0;
      if (state == IDLE && MOV) begin
        rw    <= ReadWrite;
        addr  <= Address;
        dtype <= DataType;
        sgn   <= SIGN;
        wdata <= DataIn;
        beat  <= 1'b0;
        cnt   <= CNT0;
      end
      if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (state == XFER) begin
        MOC   <= 1'b1;
        Fault <= mis;
        if (mis) DataOut <= '0;
        else if (rw) DataOut <= rdata;
      end
      if (state == BEAT2) begin
        wdata <= DataIn;
        addr  <= addr + ADDR_WIDTH'(4);
        beat  <= 1'b1;
        cnt   <= CNT0;
      end
    end
  // reset forces IDLE, so a write never lands unless its XFER edge is reached
  always_ff @(posedge Clk)
    if (state == XFER && !rw && !mis) begin
      if (dtype == 2'b00) mem[addr] <= wdata[7:0];
      else if (dtype == 2'b01) begin
        mem[addr] <= wdata[15:8];
        mem[a1]   <= wdata[7:0];
      end else begin
        mem[addr] <= wdata[31:24];
        mem[a1]   <= wdata[23:16];
        mem[a2]   <= wdata[15:8];
        mem[a3]   <= wdata[7:0];
      end
    end
endmodule
